// File: rtl/mod_counter_sequencer.sv
// Command-driven sequencer for a mod-MOD counter datapath: RUN/STOP/LOAD/CLEAR over valid/ready,
// burst-limited runs counted in whole wraps, registered strobes and status.
module mod_counter_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 6,
  parameter int BURST_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_arg,
  input  logic [BURST_W-1:0] cmd_bursts,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  output logic               busy,
  output logic               done,
  output logic               wrap_pulse,
  output logic [BURST_W-1:0] wraps_done,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam int TERM_I = MOD - 1;
  localparam int ONE_I  = 1;
  localparam logic [WIDTH-1:0]   TERM    = TERM_I[WIDTH-1:0];
  localparam logic [WIDTH:0]     MOD_EXT = MOD[WIDTH:0];
  localparam logic [BURST_W-1:0] ONE_B   = ONE_I[BURST_W-1:0];
  localparam logic [BURST_W-1:0] ZERO_B  = {BURST_W{1'b0}};

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   target_q, target_d;
  logic [BURST_W-1:0]   wraps_q, wraps_d;
  logic                 cnt_en_q, cnt_en_d;
  logic                 cnt_clr_q, cnt_clr_d;
  logic                 cnt_load_q, cnt_load_d;
  logic [WIDTH-1:0]     load_val_q, load_val_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 err_q, err_d;

  logic                 accept_s;
  logic                 wrap_s;
  logic                 final_s;
  logic [BURST_W-1:0]   wraps_inc_s;
  logic                 arg_bad_s;

  assign cmd_ready   = ~(cnt_load_q | cnt_clr_q);
  assign accept_s    = cmd_valid & cmd_ready;
  assign wrap_s      = cnt_en_q & (cnt_value == TERM);
  assign wraps_inc_s = wraps_q + ONE_B;
  assign final_s     = wrap_s & (target_q != ZERO_B) & (wraps_inc_s == target_q);
  assign arg_bad_s   = ({1'b0, cmd_arg} >= MOD_EXT);

  // Next-state, wrap accounting and command decode; CLEAR is applied last so it overrides a final wrap.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    wraps_d      = wraps_q;
    cnt_clr_d    = 1'b0;
    cnt_load_d   = 1'b0;
    load_val_d   = load_val_q;
    err_d        = 1'b0;
    wrap_pulse_d = wrap_s;

    if (wrap_s) begin
      wraps_d = wraps_inc_s;
      if (final_s) begin
        state_d = ST_DONE;
      end else begin
        state_d = state_q;
      end
    end else begin
      wraps_d = wraps_q;
    end

    if (accept_s) begin
      case (cmd_op)
        OP_RUN: begin
          if (state_q == ST_RUN) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_RUN;
            wraps_d  = ZERO_B;
            target_d = cmd_bursts;
          end
        end
        OP_STOP: begin
          if ((state_q == ST_RUN) && !final_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_d;
          end
        end
        OP_LOAD: begin
          if (state_q == ST_RUN) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            cnt_load_d = 1'b1;
            load_val_d = arg_bad_s ? {WIDTH{1'b0}} : cmd_arg;
            err_d      = arg_bad_s;
          end
        end
        OP_CLEAR: begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
          wraps_d   = ZERO_B;
        end
        default: begin
          state_d = state_d;
        end
      endcase
    end else begin
      err_d = 1'b0;
    end

    cnt_en_d = (state_d == ST_RUN);
    busy_d   = (state_d == ST_RUN);
    done_d   = (state_d == ST_DONE);
  end

  // State and registered outputs; reset drops cnt_en at once but never strobes a clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      target_q     <= {BURST_W{1'b0}};
      wraps_q      <= {BURST_W{1'b0}};
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      cnt_load_q   <= 1'b0;
      load_val_q   <= {WIDTH{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      wraps_q      <= wraps_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      cnt_load_q   <= cnt_load_d;
      load_val_q   <= load_val_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_q        <= err_d;
    end
  end

  assign cnt_en       = cnt_en_q;
  assign cnt_clr      = cnt_clr_q;
  assign cnt_load     = cnt_load_q;
  assign cnt_load_val = load_val_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign wraps_done   = wraps_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Scoreboard bench for mod_counter_sequencer with a behavioural mod-6 counter datapath.
module tb_mod_counter_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] cmd_bursts = 4'd0;
  logic [3:0] cnt_q = 4'd0;
  logic       cnt_en, cnt_clr, cnt_load, busy, done, wrap_pulse, err;
  logic [3:0] cnt_load_val, wraps_done;

  int vectors = 0;
  int miscompares = 0;
  int en_cycles;
  logic [14:0] sb[$];

  mod_counter_sequencer #(.WIDTH(4), .MOD(6), .BURST_W(4)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_bursts(cmd_bursts), .cnt_value(cnt_q),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .busy(busy), .done(done), .wrap_pulse(wrap_pulse), .wraps_done(wraps_done), .err(err)
  );

  always #5 clock = ~clock;

  // Counter datapath model: clear beats load beats increment; not touched by the sequencer reset.
  always @(posedge clock) begin
    if (cnt_clr) cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_load_val;
    else if (cnt_en) cnt_q <= (cnt_q == 4'd5) ? 4'd0 : cnt_q + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // {cnt_en, load, clr, err, wrap, done, busy, load_val, wraps_done}
  function automatic logic [14:0] ev(input logic en, input logic ld, input logic cl, input logic er,
                                     input logic wr, input logic dn, input logic bz,
                                     input logic [3:0] lv, input logic [3:0] wd);
    return {en, ld, cl, er, wr, dn, bz, lv, wd};
  endfunction

  // Monitor: any strobe/pulse cycle must match the next expected event.
  always @(negedge clock) begin
    if (!reset && (cnt_load || cnt_clr || err || wrap_pulse)) begin
      logic [14:0] act;
      act = {cnt_en, cnt_load, cnt_clr, err, wrap_pulse, done, busy,
             cnt_load_val & {4{cnt_load}}, wraps_done};
      if (sb.size() == 0) begin
        timeout("unexpected_event");
        $display("  unexpected event 0x%0h", act);
      end else begin
        check("event", {17'd0, act}, {17'd0, sb.pop_front()});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input logic [3:0] bursts);
    int n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) timeout("cmd_ready");
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; cmd_bursts = bursts;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int ens);
    int n = 0;
    ens = 0;
    @(negedge clock);
    while (!done && n < 60) begin
      if (cnt_en) ens++;
      @(negedge clock);
      n++;
    end
    if (!done) timeout(nm);
  endtask

  task automatic wait_wrap(input string nm);
    int n = 0;
    @(negedge clock);
    while (!wrap_pulse && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!wrap_pulse) timeout(nm);
  endtask

  task automatic wait_cnt(input logic [3:0] v, input string nm);
    int n = 0;
    @(negedge clock);
    while (cnt_q !== v && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (cnt_q !== v) timeout(nm);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_cnt_en", cnt_en, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done_busy", {done, busy}, 0);
    check("rst_wraps", wraps_done, 0);
    check("rst_load_val", cnt_load_val, 0);
    reset = 1'b0;

    // CLEAR then RUN bursts=2
    sb.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0));
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1));
    sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2));
    issue(2'b11, 4'd0, 4'd0);
    issue(2'b00, 4'd0, 4'd2);
    wait_done("t2_done", en_cycles);
    check("t2_en_cycles", en_cycles, 12);
    check("t2_cnt_value", cnt_q, 0);
    check("t2_wraps", wraps_done, 2);

    // LOAD 4 then RUN bursts=1
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 4'd2));
    sb.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1));
    issue(2'b10, 4'd4, 4'd0);
    issue(2'b00, 4'd0, 4'd1);
    wait_done("t3_done", en_cycles);
    check("t3_en_cycles", en_cycles, 2);
    check("t3_wraps", wraps_done, 1);
    check("t3_cnt_value", cnt_q, 0);

    // LOAD 7 (out of range)
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1));
    issue(2'b10, 4'd7, 4'd0);
    check("t4_ready_low", cmd_ready, 0);
    check("t4_load_err", {cnt_load, err}, 2'b11);
    @(posedge clock);
    #1 check("t4_ready_back", cmd_ready, 1);

    // RUN free-run, RUN during RUN, STOP as count reaches 3
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0));
    sb.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd1));
    issue(2'b00, 4'd0, 4'd0);
    issue(2'b00, 4'd0, 4'd3);
    wait_wrap("t5_wrap");
    wait_cnt(4'd2, "t5_cnt2");
    issue(2'b01, 4'd0, 4'd0);
    repeat (3) @(posedge clock);
    #1;
    check("t5_cnt_hold", cnt_q, 3);
    check("t5_en_busy", {cnt_en, busy, done}, 0);
    check("t5_wraps", wraps_done, 1);

    // LOAD 0, RUN bursts=1, CLEAR coincident with the final wrap
    sb.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1));
    sb.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0));
    issue(2'b10, 4'd0, 4'd0);
    issue(2'b00, 4'd0, 4'd1);
    wait_cnt(4'd5, "t6_cnt5");
    issue(2'b11, 4'd0, 4'd0);
    repeat (2) @(posedge clock);
    #1;
    check("t6_state", {busy, done, cnt_en}, 0);
    check("t6_wraps", wraps_done, 0);
    check("t6_cnt_value", cnt_q, 0);

    // Asynchronous reset in the middle of a RUN
    issue(2'b00, 4'd0, 4'd0);
    repeat (3) @(posedge clock);
    #2 check("t1_pre_en", cnt_en, 1);
    reset = 1'b1;
    #1;
    check("t1_cnt_en", cnt_en, 0);
    check("t1_done_busy", {done, busy}, 0);
    check("t1_wraps", wraps_done, 0);
    check("t1_ready", cmd_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("t1_stays_idle", {cnt_en, busy}, 0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
